// File: rtl/serial_alu_controller_if.sv
// serial_alu_controller_if
//   Bundles the command handshake and the bit-cell / result-mux wiring of
//   the bit-serial ALU sequencer.
//   slave  : view of the sequencer (command in, bit-cell drive out)
//   master : view of the environment (command source + bit cells + mux)
//   Signals:
//     start_i/ready_o        command valid/ready
//     op_i, a_i, b_i         opcode and operands
//     f_o                    function select to the result multiplexer
//     a_bit_o, b_bit_o       current operand bits to the bit cells
//     carry_o / carry_i      carry-or-borrow loop to/from the selected cell
//     result_bit_i           selected result bit from the multiplexer
//     result_o, flag_o       last completed word and final carry/borrow
//     done_o                 one-cycle completion pulse
interface serial_alu_controller_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MUX_WIDTH  = 3
);
  logic                  start_i;
  logic                  ready_o;
  logic [MUX_WIDTH-1:0]  op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic [MUX_WIDTH-1:0]  f_o;
  logic                  a_bit_o;
  logic                  b_bit_o;
  logic                  carry_o;
  logic                  carry_i;
  logic                  result_bit_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  flag_o;
  logic                  done_o;

  modport slave (
    input  start_i, op_i, a_i, b_i, carry_i, result_bit_i,
    output ready_o, f_o, a_bit_o, b_bit_o, carry_o, result_o, flag_o, done_o
  );

  modport master (
    output start_i, op_i, a_i, b_i, carry_i, result_bit_i,
    input  ready_o, f_o, a_bit_o, b_bit_o, carry_o, result_o, flag_o, done_o
  );
endinterface

// File: rtl/serial_alu_controller.sv
// serial_alu_controller
//   Bit-serial ALU sequencer. Accepts one command (op, A, B) in IDLE,
//   streams operand bits LSB-first to external 1-bit cells for DATA_WIDTH
//   cycles while looping carry/borrow, assembles the selected result bits
//   MSB-inserted, then publishes the word with a one-cycle done pulse.
//   Ports:
//     clk_i   clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     serial_alu_controller_if.slave (handshake + bit-cell wiring)
module serial_alu_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MUX_WIDTH  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  serial_alu_controller_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [MUX_WIDTH-1:0] OP_AND = MUX_WIDTH'(0);
  localparam logic [MUX_WIDTH-1:0] OP_ADD = MUX_WIDTH'(3);
  localparam logic [MUX_WIDTH-1:0] OP_SUB = MUX_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] res_sh;
  logic [DATA_WIDTH-1:0] res_next;
  logic [MUX_WIDTH-1:0]  op_q;
  logic                  carry_q;
  logic                  carry_next;
  logic                  is_arith;
  logic                  last_bit;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  flag_q;

  // Carry only circulates for ADD/SUB; logic ops keep the loop at zero.
  assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign carry_next = is_arith & bus.carry_i;
  assign res_next   = {bus.result_bit_i, res_sh[DATA_WIDTH-1:1]};
  assign last_bit   = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    bus.ready_o  = 1'b0;
    bus.done_o   = 1'b0;
    bus.a_bit_o  = 1'b0;
    bus.b_bit_o  = 1'b0;
    bus.carry_o  = 1'b0;
    bus.f_o      = op_q;
    bus.result_o = result_q;
    bus.flag_o   = flag_q;
    unique case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.start_i) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bus.a_bit_o = a_sh[0];
        bus.b_bit_o = b_sh[0];
        bus.carry_o = carry_q;
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand shifters, carry loop, bit counter and result capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op_q     <= OP_AND;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            a_sh    <= bus.a_i;
            b_sh    <= bus.b_i;
            // Unused opcodes fall back to AND, matching the mux default.
            op_q    <= (bus.op_i <= OP_SUB) ? bus.op_i : OP_AND;
            carry_q <= 1'b0;
            cnt_q   <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        SHIFT: begin
          res_sh  <= res_next;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= carry_next;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (last_bit) begin
            result_q <= res_next;
            flag_q   <= carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/serial_alu_controller.md
Name: serial_alu_controller

Overview:
- Bit-serial ALU sequencer that drives the 1-bit function units and the result multiplexer from the other end.
- Accepts one word-wide command through a valid/ready handshake.
- Streams operand bits LSB-first to the bit cells and drives the function select.
- Loops carry/borrow between cycles, collects the selected result bit each cycle, and returns the full word with a completion pulse.

Parameters:
DATA_WIDTH, 8, operand/result width in bits; legal range 2..32
MUX_WIDTH, 3, width of the function-select code (matches `MUX_WIDTH)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  command valid
ready_o  output  1  command ready; high only in IDLE
op_i  input  MUX_WIDTH  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB
a_i  input  DATA_WIDTH  operand A
b_i  input  DATA_WIDTH  operand B
f_o  output  MUX_WIDTH  function select to result multiplexer
a_bit_o  output  1  current A bit to bit cells
b_bit_o  output  1  current B bit to bit cells
carry_o  output  1  carry-in (ADD) / borrow-in (SUB) to bit cells
carry_i  input  1  carry-out (ADD) / borrow-out (SUB) from the selected cell
result_bit_i  input  1  multiplexer result bit
result_o  output  DATA_WIDTH  last completed result
flag_o  output  1  final carry (ADD) / borrow (SUB); 0 for logic ops
done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; ready_o=1; f_o=000; a_bit_o=b_bit_o=carry_o=0; result_o=0; flag_o=0; done_o=0; bit counter=0; operand shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1 at a clock edge: latch a_i, b_i, op_i into shift/op registers; clear the carry register; load the counter with DATA_WIDTH-1; go to SHIFT.
  - Opcodes 101..111 are latched as 000 (AND), consistent with the mux default.
- SHIFT:
  - ready_o=0.
  - Combinational outputs: f_o=latched op; a_bit_o=A_sh[0]; b_bit_o=B_sh[0]; carry_o=carry register.
  - Each edge:
    - Shift result register right, inserting result_bit_i at the MSB.
    - Shift A_sh and B_sh right.
    - Carry register <= carry_i when op is ADD/SUB, else 0.
    - Decrement the counter.
  - Exactly DATA_WIDTH SHIFT cycles. On the edge where counter==0: copy the assembled word to result_o, set flag_o from the final carry value, go to DONE.
- DONE:
  - done_o=1 for exactly this one cycle; ready_o=0.
  - Next edge: IDLE.
- Latency: command accepted at edge 0; done_o high during cycle DATA_WIDTH+1; next command accepted no earlier than edge DATA_WIDTH+2.
- Outside SHIFT: f_o holds the last op; a_bit_o, b_bit_o, carry_o are 0.
- start_i while not in IDLE is ignored; no queuing, no effect on the running operation.
- result_o and flag_o change only on completion and hold until the next completion or reset.
- Reset mid-operation:
  - Immediate return to IDLE with the reset values above.
  - Partial result discarded.
  - No done_o pulse.
- SUB semantics: bit cell computes a-b-borrow_in with borrow_out. flag_o=1 means A<B unsigned; result is two's complement modulo 2^DATA_WIDTH.
- ADD semantics: result = (A+B) mod 2^DATA_WIDTH; flag_o=1 on unsigned overflow.

Test Plan:
- ADD, A=8'h5A, B=8'h3C, start for one cycle -> exactly 8 SHIFT cycles with f_o=011, done_o pulse in cycle 9, result_o=8'h96, flag_o=0.
- SUB, A=8'h10, B=8'h20 -> result_o=8'hF0, flag_o=1. Then SUB A=8'hFF, B=8'h01 -> 8'hFE, flag_o=0.
- Logic ops, A=8'hCA, B=8'h5F:
  - AND -> 8'h4A
  - OR -> 8'hDF
  - XOR -> 8'h95
  - flag_o=0 and carry_o=0 throughout.
- Invalid op 3'b111, A=8'hF0, B=8'h3C -> f_o=000 during SHIFT, result_o=8'h30.
- Back-to-back commands:
  - Hold start_i=1 continuously with ADD 8'hFF+8'h01 -> result_o=8'h00, flag_o=1.
  - Operands changed mid-SHIFT have no effect.
  - Second command accepted only when ready_o=1 after DONE.
- Reset mid-operation:
  - Assert rst_ni=0 during SHIFT cycle 4 of an ADD -> all outputs immediately at reset values, no done_o.
  - After release, a fresh XOR 8'hAA^8'h55 -> 8'hFF.
